sink_controller: RTL

SINK_CONTROLLER -- requirements
Module: sink_controller

---
 rtl/sink_controller_pkg.sv | 38 +++
 rtl/sink_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sink_controller_pkg.sv
// -----------------------------------------------------------------------------
// sink_controller_pkg
// Shared bridge definitions: FSM state encoding, request packet field
// positions and response packet layout.
//   Request packet (MSB first): {rd0_wr1, valid, addr[ADDR_WIDTH], wr_data[DATA_WIDTH]}
//   Response packet (MSB first): {rd_valid, rd_data[DATA_WIDTH]}
// -----------------------------------------------------------------------------
package sink_controller_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL   = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RSP_PUSH = 3'd3,
        ST_SLEEP    = 3'd4
    } state_e;

    // Direction bit sits at the top of the request packet (1 = write).
    function automatic int unsigned pkt_rd0_wr1_pos(input int unsigned pkt_w);
        return pkt_w - 1;
    endfunction

    // Valid bit sits directly below the direction bit.
    function automatic int unsigned pkt_valid_pos(input int unsigned pkt_w);
        return pkt_w - 2;
    endfunction

    // Address field starts right above the write data field.
    function automatic int unsigned pkt_addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    // Response valid flag sits above the read data.
    function automatic int unsigned rsp_valid_pos(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/sink_controller.sv
// -----------------------------------------------------------------------------
// sink_controller
// Drains a show-ahead request FIFO, issues one downstream transaction at a
// time, pushes read responses into a response FIFO and handles the sink/source
// sleep handshake.
// Ports:
//   i_clk_sink, i_rstn_sink          clock, async active-low reset
//   i_sink_sleep_req, source_sleep_status   sleep requests
//   i_req_packet, req_fifo_empty, req_fifo_rd_en   request FIFO side
//   rsp_fifo_full, rsp_fifo_empty, rsp_fifo_wr_en, o_rsp_packet  response FIFO side
//   o_rd0_wr1, o_addr, o_wr_data, o_valid, i_ready, i_rd_data, i_rd_valid  master side
//   o_sink_sleep_ack, sink_sleep_status    sleep handshake outputs
// -----------------------------------------------------------------------------
module sink_controller
    import sink_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned packet_width = ADDR_WIDTH + DATA_WIDTH + 2
) (
    input  logic                    i_clk_sink,
    input  logic                    i_rstn_sink,
    input  logic                    i_sink_sleep_req,
    input  logic                    source_sleep_status,
    input  logic [packet_width-1:0] i_req_packet,
    input  logic                    req_fifo_empty,
    output logic                    req_fifo_rd_en,
    input  logic                    rsp_fifo_full,
    input  logic                    rsp_fifo_empty,
    output logic                    rsp_fifo_wr_en,
    output logic [DATA_WIDTH:0]     o_rsp_packet,
    output logic                    o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    input  logic [DATA_WIDTH-1:0]   i_rd_data,
    input  logic                    i_rd_valid,
    output logic                    o_sink_sleep_ack,
    output logic                    sink_sleep_status
);

    localparam int unsigned P_RD0_WR1 = pkt_rd0_wr1_pos(packet_width);
    localparam int unsigned P_VALID   = pkt_valid_pos(packet_width);
    localparam int unsigned P_ADDR    = pkt_addr_lsb(DATA_WIDTH);
    localparam int unsigned P_RSP_VLD = rsp_valid_pos(DATA_WIDTH);

    state_e                  r_state;
    state_e                  w_state_next;
    logic                    r_hold_rd0_wr1;
    logic [ADDR_WIDTH-1:0]   r_hold_addr;
    logic [DATA_WIDTH-1:0]   r_hold_wr_data;
    logic [DATA_WIDTH:0]     r_rsp_packet;

    logic w_sleep_req;
    logic w_pop;
    logic w_capture;
    logic w_valid;
    logic w_push;
    logic w_ack;
    logic w_status;

    assign w_sleep_req = i_sink_sleep_req | source_sleep_status;

    // State register
    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_valid      = 1'b0;
        w_push       = 1'b0;
        w_ack        = 1'b0;
        w_status     = 1'b0;
        unique case (r_state)
            ST_NORMAL: begin
                // A nonempty FIFO is drained even while sleep is requested.
                if (!req_fifo_empty) begin
                    w_pop = 1'b1;
                    if (i_req_packet[P_VALID]) begin
                        w_state_next = ST_ISSUE;
                    end
                end else if (w_sleep_req) begin
                    w_state_next = ST_SLEEP;
                end
            end
            ST_ISSUE: begin
                w_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = r_hold_rd0_wr1 ? ST_NORMAL : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (i_rd_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RSP_PUSH;
                end
            end
            ST_RSP_PUSH: begin
                if (!rsp_fifo_full) begin
                    w_push       = 1'b1;
                    w_state_next = ST_NORMAL;
                end
            end
            ST_SLEEP: begin
                // Both flags follow i_sink_sleep_req, so they drop in the exit cycle.
                w_status = i_sink_sleep_req;
                w_ack    = i_sink_sleep_req & req_fifo_empty & rsp_fifo_empty;
                if (!w_sleep_req) begin
                    w_state_next = ST_NORMAL;
                end
            end
            default: begin
                w_state_next = ST_NORMAL;
            end
        endcase
    end

    // Holding register for the popped request
    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            r_hold_rd0_wr1 <= 1'b0;
            r_hold_addr    <= '0;
            r_hold_wr_data <= '0;
        end else if (w_pop) begin
            r_hold_rd0_wr1 <= i_req_packet[P_RD0_WR1];
            r_hold_addr    <= i_req_packet[P_ADDR +: ADDR_WIDTH];
            r_hold_wr_data <= i_req_packet[DATA_WIDTH-1:0];
        end
    end

    // Read response register, held until pushed
    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            r_rsp_packet <= '0;
        end else if (w_capture) begin
            r_rsp_packet[P_RSP_VLD]      <= 1'b1;
            r_rsp_packet[DATA_WIDTH-1:0] <= i_rd_data;
        end
    end

    // Pop is gated by reset since the reset state would otherwise pop a nonempty FIFO.
    assign req_fifo_rd_en    = w_pop & i_rstn_sink;
    assign rsp_fifo_wr_en    = w_push;
    assign o_rsp_packet      = r_rsp_packet;
    assign o_valid           = w_valid;
    assign o_rd0_wr1         = r_hold_rd0_wr1;
    assign o_addr            = r_hold_addr;
    assign o_wr_data         = r_hold_wr_data;
    assign o_sink_sleep_ack  = w_ack;
    assign sink_sleep_status = w_status;

endmodule
